// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: operation encodings and sequencer states.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MOD = 2'b10,
    RSV = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    MX_START = 3'd2,
    MX_WAIT  = 3'd3,
    RESP     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/cycle_counter.sv
// Saturating wait counter with clear/enable; tc flags the enabled cycle whose
// increment brings the count up to TIMEOUT.
module cycle_counter #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT);

  logic [CW-1:0] count;
  logic [CW:0]   count_inc;

  assign count_inc = {1'b0, count} + 1'b1;
  assign tc        = en && (count_inc == LIMIT);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && ({1'b0, count} != LIMIT)) begin
      // Saturate at TIMEOUT rather than wrap.
      count <= count_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue-stage sequencer: registers an operation for the ALU, waits for the
// result (fixed latency or mod-exp handshake with timeout) and holds it until taken.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ARQ     = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_op,
  input  logic [ARQ-1:0] in_d1,
  input  logic [ARQ-1:0] in_d2,
  input  logic [ARQ-1:0] in_d3,
  output logic [ARQ-1:0] alu_data1,
  output logic [ARQ-1:0] alu_data2,
  output logic [ARQ-1:0] alu_data3,
  output logic [1:0]     alu_ctrl,
  input  logic [ARQ-1:0] alu_result,
  input  logic           alu_z,
  output logic           mx_start,
  input  logic           mx_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ARQ-1:0] out_result,
  output logic           out_z,
  output logic           out_err,
  output logic           busy
);

  seq_state_t state, state_next;
  logic       accept;
  logic       cap_alu;
  logic       cap_err;
  logic       wait_tc;

  cycle_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == MX_START),
    .en  (state == MX_WAIT),
    .tc  (wait_tc)
  );

  // in_ready is a flop, so accept depends only on in_valid and registered state.
  assign accept = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cap_alu    = 1'b0;
    cap_err    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (alu_op_t'(in_op))
            ADD, SUB: state_next = EXEC;
            MOD:      state_next = MX_START;
            default: begin
              state_next = RESP;
              cap_err    = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        cap_alu    = 1'b1;
        state_next = RESP;
      end
      MX_START: state_next = MX_WAIT;
      MX_WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (mx_done) begin
          cap_alu    = 1'b1;
          state_next = RESP;
        end else if (wait_tc) begin
          cap_err    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: the datapath registers are explicitly reset because their values are
  // visible on ports during and right after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      alu_data1  <= '0;
      alu_data2  <= '0;
      alu_data3  <= '0;
      alu_ctrl   <= '0;
      out_result <= '0;
      out_z      <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      in_ready <= (state_next == IDLE);
      if (accept) begin
        alu_data1 <= in_d1;
        alu_data2 <= in_d2;
        alu_data3 <= in_d3;
        alu_ctrl  <= in_op;
      end
      if (cap_alu) begin
        out_result <= alu_result;
        out_z      <= alu_z;
        out_err    <= 1'b0;
      end else if (cap_err) begin
        out_result <= '0;
        out_z      <= 1'b0;
        out_err    <= 1'b1;
      end
    end
  end

  assign mx_start  = (state == MX_START);
  assign out_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter ARQ, default 16, datapath width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum wait in cycles for a mod-exp completion.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  operation request from the issue stage.
REQ-006 in_ready  out  1  sequencer can accept a request.
REQ-007 in_op  in  2  operation: 00 add, 01 sub, 10 mod-exp, 11 reserved.
REQ-008 in_d1, in_d2, in_d3  in  ARQ each  operands.
REQ-009 alu_data1, alu_data2, alu_data3  out  ARQ each  registered operands driven to the ALU.
REQ-010 alu_ctrl  out  2  registered operation select to the ALU.
REQ-011 alu_result  in  ARQ  ALU result.
REQ-012 alu_z  in  1  ALU zero flag.
REQ-013 mx_start  out  1  one-cycle start pulse to the mod-exp unit.
REQ-014 mx_done  in  1  mod-exp completion.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_result  out  ARQ  captured result.
REQ-018 out_z  out  1  captured zero flag.
REQ-019 out_err  out  1  timeout or illegal operation.
REQ-020 busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 SHALL implement the states IDLE, EXEC, MX_START, MX_WAIT and RESP.
REQ-022 SHALL drive in_ready=1 only in IDLE; a request is accepted on the edge where in_valid&&in_ready.
REQ-023 SHALL, on acceptance, register in_d1..3 into alu_data1..3 and in_op into alu_ctrl; these hold stable until the next acceptance.
REQ-024 SHALL, on acceptance, go to EXEC for op 00 or 01, to MX_START for op 10, and to RESP for op 11.
REQ-025 SHALL, for op 11, set out_err=1, out_result=0 and out_z=0.
REQ-026 SHALL, in EXEC, capture alu_result and alu_z into out_result and out_z with out_err=0, then go to RESP.
REQ-027 Add/sub latency SHALL be 2 edges: out_valid rises exactly 2 cycles after the accepting edge.
REQ-028 SHALL drive mx_start=1 only during the single MX_START cycle, clear the wait counter, then go to MX_WAIT.
REQ-029 SHALL, in MX_WAIT, increment the counter each cycle and sample mx_done only in this state.
REQ-030 SHALL, when mx_done=1 in MX_WAIT, capture alu_result and alu_z with out_err=0 and go to RESP.
REQ-031 SHALL, when the counter reaches TIMEOUT without mx_done, set out_err=1, out_result=0 and out_z=0, then go to RESP.
REQ-032 SHALL let done win when mx_done and the timeout occur in the same cycle.
REQ-033 SHALL hold out_valid=1 in RESP with out_result, out_z and out_err stable until out_ready=1; the handshake edge returns the state to IDLE.
REQ-034 SHALL keep in_ready low in RESP, so a new request is accepted no earlier than the cycle after the out handshake.
REQ-035 SHALL have no combinational path from any input to any output.
REQ-036 SHALL ignore mx_done outside MX_WAIT.
REQ-037 SHALL keep the wait counter width at $clog2(TIMEOUT+1) bits and never let it wrap.

Reset
REQ-038 SHALL, while rst=0 at an edge, force IDLE with every output 0, including alu_data*, alu_ctrl, mx_start, out_* and busy; in_ready=0 during reset.
REQ-039 SHALL let reset mid-operation abort it with no out_valid pulse; a pending mx_done is then ignored.
REQ-040 SHALL raise in_ready=1 on the first edge after rst returns high.

Structure
REQ-041 alu_pkg SHALL hold alu_op_t (ADD=2'b00, SUB=2'b01, MOD=2'b10, RSV=2'b11) and seq_state_t.
REQ-042 The wait counter SHALL be one sub-module, cycle_counter (clear, enable, count, terminal-count compare against TIMEOUT).

Verification
REQ-043 Add: accept op 00 with d1=0x0005 and d2=0x0003; the ALU model returns 0x0008 -> out_valid 2 cycles later, out_result=0x0008, out_z=0, out_err=0.
REQ-044 Sub to zero: op 01 with d1=d2=0x1234 -> out_result=0x0000, out_z=1; hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-045 Mod-exp: op 10 with mx_done asserted 37 cycles after mx_start -> mx_start is exactly 1 cycle wide, out_valid the edge after done, out_err=0.
REQ-046 Timeout: op 10 with mx_done never asserted and TIMEOUT=1023 -> out_valid after 1023 MX_WAIT cycles, out_err=1, out_result=0.
REQ-047 Illegal/reset: op 11 -> out_err=1 after 1 cycle; then op 10 with rst=0 applied mid-MX_WAIT -> all outputs 0, no out_valid, in_ready=1 the edge after release.
